// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and constants for the time-multiplexed nibble adder controller.
package adder_ctrl_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_share_ctrl_if.sv
// Request/operand/result bundle between the two requesters and the shared adder controller.
interface adder_share_ctrl_if #(parameter int NIBBLES = 4);
  import adder_ctrl_pkg::*;
  localparam int W = NIBBLE_W * NIBBLES;

  logic [1:0]   req;
  logic [W-1:0] A0, B0, A1, B1;
  logic         Cin0, Cin1;
  logic [1:0]   ack;
  logic [1:0]   done;
  logic [W-1:0] S;
  logic         Cout;
  logic         busy;
  logic         grant_id;

  modport master (
    output req, A0, B0, Cin0, A1, B1, Cin1,
    input  ack, done, S, Cout, busy, grant_id
  );

  modport slave (
    input  req, A0, B0, Cin0, A1, B1, Cin1,
    output ack, done, S, Cout, busy, grant_id
  );
endinterface

// File: rtl/adder_share_ctrl_fa4.sv
// Single 4-bit ripple slice; reused once per nibble by the controller.
module fourBitFullAdder
  import adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/adder_share_ctrl.sv
// Two-requester round-robin controller that performs a W-bit add one nibble
// per cycle through a single shared 4-bit adder.
module adder_share_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_share_ctrl_if.slave   bus
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t state_q, state_d;

  logic [IDX_W-1:0]    idx_q;
  logic                carry_q;
  logic                last_q;
  logic                grant_q;
  logic [W-1:0]        a_q, b_q, res_q, res_d, s_q;
  logic                cout_q;

  logic                winner;
  logic                start;
  logic                add_en;
  logic                last_nib;
  logic [1:0]          ack_d, done_d;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_co;

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    winner = 1'b0;
    case (bus.req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_q;
      default: winner = 1'b0;
    endcase
  end

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ack is combinational so it lands in the same cycle req is seen; gated so reset forces it low.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    add_en  = 1'b0;
    ack_d   = '0;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (rst_n && (bus.req != 2'b00)) begin
          start         = 1'b1;
          ack_d[winner] = 1'b1;
          state_d       = ADD;
        end
      end
      ADD: begin
        add_en = 1'b1;
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        done_d[grant_q] = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign nib_a = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

  fourBitFullAdder u_fa (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_s),
    .cout (nib_co)
  );

  always_comb begin
    res_d = res_q;
    res_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = nib_s;
  end

  // S/Cout load on the final ADD edge so they show the new result exactly from DONE onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      if (start) begin
        a_q     <= winner ? bus.A1 : bus.A0;
        b_q     <= winner ? bus.B1 : bus.B0;
        carry_q <= winner ? bus.Cin1 : bus.Cin0;
        grant_q <= winner;
        last_q  <= winner;
        idx_q   <= '0;
      end
      if (add_en) begin
        res_q   <= res_d;
        carry_q <= nib_co;
        idx_q   <= last_nib ? '0 : idx_q + 1'b1;
        if (last_nib) begin
          s_q    <= res_d;
          cout_q <= nib_co;
        end
      end
    end
  end

  assign bus.ack      = ack_d;
  assign bus.done     = done_d;
  assign bus.S        = s_q;
  assign bus.Cout     = cout_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Randomised scoreboard bench for adder_share_ctrl against a cycle-level arithmetic/arbitration model.
module tb_adder_share_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int LAT     = NIBBLES + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_share_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  adder_share_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int           id;
    logic [W-1:0] s;
    logic         co;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   winners[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic [1:0]   pend;
  logic [W-1:0] opa[2];
  logic [W-1:0] opb[2];
  logic         opc[2];
  int           last_srv = 1;
  bit           have_ack = 1'b0;
  int           t_ack    = 0;
  int           gid      = 0;
  bit           allow_new = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] oh(input int i);
    return (i == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic bit model_idle();
    return !have_ack || ((cyc - t_ack) >= NIBBLES + 2);
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(5))
      0:       v = '1;
      1:       v = '0;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    bus.req  = pend;
    bus.A0   = opa[0];
    bus.B0   = opb[0];
    bus.Cin0 = opc[0];
    bus.A1   = opa[1];
    bus.B1   = opb[1];
    bus.Cin1 = opc[1];
  endtask

  // Sample at the negedge of cycle c, then drive the next cycle's inputs just after its rising edge.
  task automatic step();
    int           w;
    logic [1:0]   exp_ack;
    logic [W:0]   full;
    @(negedge clk);
    exp_ack = '0;
    check("busy", 32'(bus.busy), 32'(!model_idle()));
    if (!model_idle()) check("grant_id", 32'(bus.grant_id), 32'(gid));
    if (model_idle() && pend != 2'b00) begin
      if (pend == 2'b01)      w = 0;
      else if (pend == 2'b10) w = 1;
      else                    w = 1 - last_srv;
      exp_ack = oh(w);
      full = {1'b0, opa[w]} + {1'b0, opb[w]} + (W+1)'(opc[w]);
      sb.push_back('{id: w, s: full[W-1:0], co: full[W], due: cyc + LAT});
      winners.push_back(w);
      last_srv = w;
      gid      = w;
      have_ack = 1'b1;
      t_ack    = cyc;
      pend[w]  = 1'b0;
    end
    check("ack", 32'(bus.ack), 32'(exp_ack));
    @(posedge clk);
    #1;
    // Scramble operands of the requester just served: must not disturb the add in flight.
    if (exp_ack != 2'b00) begin
      for (int i = 0; i < 2; i++) begin
        if (exp_ack[i]) begin
          opa[i] = rand_op();
          opb[i] = rand_op();
          opc[i] = 1'($urandom);
        end
      end
    end
    if (allow_new) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(3) == 0) begin
            pend[i] = 1'b1;
            opa[i]  = rand_op();
            opb[i]  = rand_op();
            opc[i]  = 1'($urandom);
          end
        end else if ($urandom_range(15) == 0) begin
          pend[i] = 1'b0;
        end
      end
    end
    drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    allow_new = 1'b0;
    while (!(model_idle() && sb.size() == 0 && pend == 2'b00) && n < 200) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(n >= 200), 32'(0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.done != 2'b00) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected at cycle %0d: done=%b, expected none", cyc, bus.done);
        end else begin
          e = sb.pop_front();
          check("done", 32'(bus.done), 32'(oh(e.id)));
          check("done_cycle", 32'(cyc), 32'(e.due));
          check("S", 32'(bus.S), 32'(e.s));
          check("Cout", 32'(bus.Cout), 32'(e.co));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        tests++;
        fails++;
        $display("FAIL done_missing at cycle %0d: done=00, expected %b", cyc, oh(e.id));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      opa[i] = '0;
      opb[i] = '0;
      opc[i] = 1'b0;
    end
    pend = 2'b11;
    drive();
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(bus.ack), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_S", 32'(bus.S), 32'(0));
    check("rst_Cout", 32'(bus.Cout), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_grant", 32'(bus.grant_id), 32'(0));
    pend = 2'b00;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Tie straight after reset: requester 0 first, then requester 1.
    winners.delete();
    opa[0] = 16'h1111; opb[0] = 16'h2222; opc[0] = 1'b0;
    opa[1] = 16'h000F; opb[1] = 16'h0001; opc[1] = 1'b1;
    pend = 2'b11;
    drive();
    drain();
    check("tie_count", 32'(winners.size()), 32'(2));
    if (winners.size() == 2) begin
      check("tie_first", 32'(winners[0]), 32'(0));
      check("tie_second", 32'(winners[1]), 32'(1));
    end
    check("tie_S", 32'(bus.S), 32'h0011);
    check("tie_Cout", 32'(bus.Cout), 32'(0));

    // Single request.
    opa[0] = 16'h1234; opb[0] = 16'h4321; opc[0] = 1'b0; pend = 2'b01; drive();
    drain();
    check("single_S", 32'(bus.S), 32'h5555);
    check("single_Cout", 32'(bus.Cout), 32'(0));

    // Carry ripple through every nibble.
    opa[0] = 16'hFFFF; opb[0] = 16'h0001; opc[0] = 1'b0; pend = 2'b01; drive();
    drain();
    check("ripple_S", 32'(bus.S), 32'h0000);
    check("ripple_Cout", 32'(bus.Cout), 32'(1));

    // Carry-in only.
    opa[0] = 16'hFFFF; opb[0] = 16'h0000; opc[0] = 1'b1; pend = 2'b01; drive();
    drain();
    check("cin_S", 32'(bus.S), 32'h0000);
    check("cin_Cout", 32'(bus.Cout), 32'(1));

    // Leave a non-zero S, then abort a transaction with reset at T+2.
    opa[1] = 16'h0F0F; opb[1] = 16'h0101; opc[1] = 1'b0; pend = 2'b10; drive();
    drain();
    winners.delete();
    opa[0] = 16'hAAAA; opb[0] = 16'h5555; opc[0] = 1'b1; pend = 2'b01; drive();
    for (int n = 0; n < 20 && winners.size() == 0; n++) step();
    check("abort_acked", 32'(winners.size()), 32'(1));
    step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_S", 32'(bus.S), 32'(0));
    check("abort_Cout", 32'(bus.Cout), 32'(0));
    check("abort_done", 32'(bus.done), 32'(0));
    sb.delete();
    pend     = 2'b00;
    have_ack = 1'b0;
    last_srv = 1;
    drive();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    opa[0] = 16'h0102; opb[0] = 16'h0304; opc[0] = 1'b0; pend = 2'b01; drive();
    drain();
    check("after_abort_S", 32'(bus.S), 32'h0406);

    // Random traffic with overlapping requests, withdrawals and operand churn.
    allow_new = 1'b1;
    repeat (400) step();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
